datapath_seq: RTL and testbench

Parametrised successor to the lab 6 datapath: a W-bit, NREG-entry register-file datapath with shifter, ALU, C result register and status flags, plus an integrated micro-sequencer. The controller no longer drives loada/loadb/loadc/write per cycle. It hands over one command through a valid/ready handshake, and the block sequences operand fetch, execute and writeback itself, pulsing `done` at completion. It sits between the instruction decoder and the register file in the lab 7/8 CPU.

---
 rtl/datapath_seq.sv | 215 +++++++++++++++++++++
 tb/tb_datapath_seq.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/datapath_seq.sv
// Register-file datapath (shifter, ALU, C register, {N,V,Z} flags) driven by a
// one-command micro-sequencer. Define DATAPATH_SEQ_OVF_EN to build the V-flag overflow logic.
module datapath_seq #(
    parameter int W    = 16,
    parameter int NREG = 8,
    localparam int RA  = $clog2(NREG)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [1:0]    cmd_mode,
    input  logic [1:0]    cmd_aluop,
    input  logic [1:0]    cmd_shift,
    input  logic [RA-1:0] cmd_rd,
    input  logic [RA-1:0] cmd_rn,
    input  logic [RA-1:0] cmd_rm,
    input  logic [7:0]    cmd_imm,
    output logic          done,
    output logic [W-1:0]  dp_out,
    output logic [2:0]    status,
    input  logic [RA-1:0] dbg_rnum,
    output logic [W-1:0]  dbg_rdata
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] FETCH_A = 3'd1;
    localparam logic [2:0] FETCH_B = 3'd2;
    localparam logic [2:0] EXEC    = 3'd3;
    localparam logic [2:0] WB      = 3'd4;

    localparam logic [1:0] M_MOVI = 2'b00;
    localparam logic [1:0] M_ALUR = 2'b01;
    localparam logic [1:0] M_ALUI = 2'b10;
    localparam logic [1:0] M_CMP  = 2'b11;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_NOT = 2'b11;

    localparam logic [1:0] SH_NONE = 2'b00;
    localparam logic [1:0] SH_LSL  = 2'b01;
    localparam logic [1:0] SH_LSR  = 2'b10;
    localparam logic [1:0] SH_ASR  = 2'b11;

    function automatic logic signed [W-1:0] sext8(input logic signed [7:0] v);
        return W'(v);
    endfunction

    function automatic logic signed [W-1:0] sext5(input logic signed [4:0] v);
        return W'(v);
    endfunction

    function automatic logic [W-1:0] shift_one(input logic [W-1:0] v, input logic [1:0] sh);
        logic [W-1:0] r;
        case (sh)
            SH_LSL:  r = {v[W-2:0], 1'b0};
            SH_LSR:  r = {1'b0, v[W-1:1]};
            SH_ASR:  r = {v[W-1], v[W-1:1]};
            default: r = v;
        endcase
        return r;
    endfunction

    function automatic logic [W-1:0] alu_calc(input logic [1:0] op,
                                              input logic [W-1:0] a,
                                              input logic [W-1:0] b);
        logic [W-1:0] r;
        case (op)
            OP_ADD:  r = a + b;
            OP_SUB:  r = a - b;
            OP_AND:  r = a & b;
            default: r = ~b;
        endcase
        return r;
    endfunction

`ifdef DATAPATH_SEQ_OVF_EN
    // Signed overflow: operands agree in sign (ADD) or differ (SUB) and the result flips sign.
    function automatic logic alu_ovf(input logic [1:0] op,
                                     input logic signed [W-1:0] a,
                                     input logic signed [W-1:0] b,
                                     input logic signed [W-1:0] r);
        logic ov;
        case (op)
            OP_ADD:  ov = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
            OP_SUB:  ov = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
            default: ov = 1'b0;
        endcase
        return ov;
    endfunction
`endif

    logic [2:0]    state;
    logic [2:0]    state_nxt;
    logic          accept;

    logic [1:0]    c_mode;
    logic [1:0]    c_aluop;
    logic [1:0]    c_shift;
    logic [RA-1:0] c_rd;
    logic [RA-1:0] c_rn;
    logic [RA-1:0] c_rm;
    logic [7:0]    c_imm;

    logic [W-1:0]  a_reg;
    logic [W-1:0]  b_reg;
    logic [W-1:0]  c_reg;
    logic [W-1:0]  op_b;
    logic [W-1:0]  alu_res;
    logic          flag_load;
    logic          n_flag;
    logic          z_flag;
    logic          v_flag;

    logic [W-1:0]  rf [NREG];

    assign accept    = cmd_valid && (state == IDLE);
    assign flag_load = (state == EXEC) && (c_mode != M_MOVI);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = (cmd_mode == M_MOVI) ? EXEC : FETCH_A;
            FETCH_A: state_nxt = FETCH_B;
            FETCH_B: state_nxt = EXEC;
            EXEC:    state_nxt = (c_mode == M_CMP) ? IDLE : WB;
            WB:      state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // Command register: the handshake edge is the only point the cmd_* inputs are sampled.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            c_mode  <= '0;
            c_aluop <= '0;
            c_shift <= '0;
            c_rd    <= '0;
            c_rn    <= '0;
            c_rm    <= '0;
            c_imm   <= '0;
        end else if (accept) begin
            c_mode  <= cmd_mode;
            c_aluop <= cmd_aluop;
            c_shift <= cmd_shift;
            c_rd    <= cmd_rd;
            c_rn    <= cmd_rn;
            c_rm    <= cmd_rm;
            c_imm   <= cmd_imm;
        end
    end

    always_comb begin
        op_b    = (c_mode == M_ALUI) ? sext5(c_imm[4:0]) : shift_one(b_reg, c_shift);
        alu_res = alu_calc(c_aluop, a_reg, op_b);
    end

    // Operand fetch and execute
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_reg <= '0;
            b_reg <= '0;
            c_reg <= '0;
        end else begin
            if (state == FETCH_A) a_reg <= rf[c_rn];
            if (state == FETCH_B) b_reg <= rf[c_rm];
            if (state == EXEC) begin
                if (c_mode == M_MOVI)     c_reg <= sext8(c_imm);
                else if (c_mode != M_CMP) c_reg <= alu_res;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            n_flag <= 1'b0;
            z_flag <= 1'b0;
        end else if (flag_load) begin
            n_flag <= alu_res[W-1];
            z_flag <= (alu_res == '0);
        end
    end

`ifdef DATAPATH_SEQ_OVF_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)       v_flag <= 1'b0;
        else if (flag_load) v_flag <= alu_ovf(c_aluop, a_reg, op_b, alu_res);
    end
`else
    assign v_flag = 1'b0;
`endif

    // Writeback
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NREG; i++) rf[i] <= '0;
        end else if (state == WB) begin
            rf[c_rd] <= c_reg;
        end
    end

    assign cmd_ready = (state == IDLE);
    assign done      = (state == WB) || ((state == EXEC) && (c_mode == M_CMP));
    assign dp_out    = c_reg;
    assign status    = {n_flag, v_flag, z_flag};
    assign dbg_rdata = rf[dbg_rnum];

endmodule

// File: tb/tb_datapath_seq.sv
// Directed bench for datapath_seq: a W=16/NREG=8 instance driven from a vector table
// and a W=32/NREG=16 instance for the wide ALUR / ASR sign-fill case.
module tb_datapath_seq;

    typedef struct {
        logic [1:0]  mode;
        logic [1:0]  op;
        logic [1:0]  sh;
        logic [3:0]  rd;
        logic [3:0]  rn;
        logic [3:0]  rm;
        logic [7:0]  imm;
        logic [31:0] exp_dp;
        logic [2:0]  exp_st;
        logic [31:0] exp_reg;
        int          exp_lat;
    } vec_t;

`ifdef DATAPATH_SEQ_OVF_EN
    localparam logic OVF = 1'b1;
`else
    localparam logic OVF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic        sel;
    logic        cmd_valid;
    logic [1:0]  c_mode, c_op, c_sh;
    logic [3:0]  c_rd, c_rn, c_rm, dbg_rnum;
    logic [7:0]  c_imm;

    logic        v16, v32;
    logic        ready16, done16, ready32, done32;
    logic [15:0] dp16, dbg16;
    logic [31:0] dp32, dbg32;
    logic [2:0]  st16, st32;

    logic        ready_m, done_m;
    logic [31:0] dp_m, dbg_m;
    logic [2:0]  st_m;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    assign v16     = cmd_valid & ~sel;
    assign v32     = cmd_valid & sel;
    assign ready_m = sel ? ready32 : ready16;
    assign done_m  = sel ? done32 : done16;
    assign dp_m    = sel ? dp32 : {16'h0, dp16};
    assign st_m    = sel ? st32 : st16;
    assign dbg_m   = sel ? dbg32 : {16'h0, dbg16};

    datapath_seq #(.W(16), .NREG(8)) dut16 (
        .clk(clk), .reset_n(reset_n), .cmd_valid(v16), .cmd_ready(ready16),
        .cmd_mode(c_mode), .cmd_aluop(c_op), .cmd_shift(c_sh),
        .cmd_rd(c_rd[2:0]), .cmd_rn(c_rn[2:0]), .cmd_rm(c_rm[2:0]), .cmd_imm(c_imm),
        .done(done16), .dp_out(dp16), .status(st16),
        .dbg_rnum(dbg_rnum[2:0]), .dbg_rdata(dbg16)
    );

    datapath_seq #(.W(32), .NREG(16)) dut32 (
        .clk(clk), .reset_n(reset_n), .cmd_valid(v32), .cmd_ready(ready32),
        .cmd_mode(c_mode), .cmd_aluop(c_op), .cmd_shift(c_sh),
        .cmd_rd(c_rd), .cmd_rn(c_rn), .cmd_rm(c_rm), .cmd_imm(c_imm),
        .done(done32), .dp_out(dp32), .status(st32),
        .dbg_rnum(dbg_rnum), .dbg_rdata(dbg32)
    );

    function automatic vec_t mk(input logic [1:0] mode, op, sh, input logic [3:0] rd, rn, rm,
                                input logic [7:0] imm, input logic [31:0] dp,
                                input logic [2:0] st, input logic [31:0] rv, input int lat);
        vec_t v;
        v.mode = mode; v.op = op; v.sh = sh; v.rd = rd; v.rn = rn; v.rm = rm; v.imm = imm;
        v.exp_dp = dp; v.exp_st = st; v.exp_reg = rv; v.exp_lat = lat;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        c_mode = v.mode; c_op = v.op; c_sh = v.sh;
        c_rd = v.rd; c_rn = v.rn; c_rm = v.rm; c_imm = v.imm;
    endtask

    task automatic read_reg(input logic [3:0] r, output logic [31:0] val);
        dbg_rnum = r;
        #1;
        val = dbg_m;
    endtask

    // Returns at the falling edge of the first cycle after done; lat counts cycles from accept.
    task automatic issue(input vec_t v, output int lat);
        @(negedge clk);
        drive(v);
        cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        lat = -1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (done_m === 1'b1) begin
                lat = k;
                break;
            end
        end
        @(negedge clk);
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int lat;
        logic [31:0] rv;
        issue(v, lat);
        check({tag, ".latency"}, 32'(lat), 32'(v.exp_lat));
        check({tag, ".dp_out"}, dp_m, v.exp_dp);
        check({tag, ".status"}, {29'h0, st_m}, {29'h0, v.exp_st});
        check({tag, ".ready"}, {31'h0, ready_m}, 32'h1);
        read_reg(v.rd, rv);
        check({tag, ".reg"}, rv, v.exp_reg);
    endtask

    vec_t tbl[15];
    vec_t t32[4];

    initial begin
        logic [2:0]  st_ov;
        logic [31:0] rv;
        int          lat, first, second, done_at, nacc, done_seen;
        vec_t        va, vb;

        st_ov = {1'b1, OVF, 1'b0};
        //                  mode   op     sh     rd  rn  rm  imm     dp            st     reg           lat
        tbl[0]  = mk(2'b00, 2'b00, 2'b00, 1, 0, 0, 8'h03, 32'h0003, 3'b000, 32'h0003, 2);
        tbl[1]  = mk(2'b00, 2'b00, 2'b00, 2, 0, 0, 8'h05, 32'h0005, 3'b000, 32'h0005, 2);
        tbl[2]  = mk(2'b01, 2'b00, 2'b01, 4, 1, 2, 8'h00, 32'h000D, 3'b000, 32'h000D, 4);
        tbl[3]  = mk(2'b00, 2'b00, 2'b00, 1, 0, 0, 8'hF0, 32'hFFF0, 3'b000, 32'hFFF0, 2);
        tbl[4]  = mk(2'b00, 2'b00, 2'b00, 5, 0, 0, 8'hFF, 32'hFFFF, 3'b000, 32'hFFFF, 2);
        tbl[5]  = mk(2'b01, 2'b00, 2'b10, 0, 7, 5, 8'h00, 32'h7FFF, 3'b000, 32'h7FFF, 4);
        tbl[6]  = mk(2'b11, 2'b01, 2'b00, 3, 0, 5, 8'h00, 32'h7FFF, st_ov,  32'h0000, 3);
        tbl[7]  = mk(2'b00, 2'b00, 2'b00, 6, 0, 0, 8'h02, 32'h0002, st_ov,  32'h0002, 2);
        tbl[8]  = mk(2'b10, 2'b01, 2'b00, 6, 6, 0, 8'h02, 32'h0000, 3'b001, 32'h0000, 4);
        tbl[9]  = mk(2'b01, 2'b10, 2'b00, 7, 1, 5, 8'h00, 32'hFFF0, 3'b100, 32'hFFF0, 4);
        tbl[10] = mk(2'b01, 2'b11, 2'b01, 3, 0, 2, 8'h00, 32'hFFF5, 3'b100, 32'hFFF5, 4);
        tbl[11] = mk(2'b10, 2'b00, 2'b00, 2, 0, 0, 8'h01, 32'h8000, st_ov,  32'h8000, 4);
        tbl[12] = mk(2'b01, 2'b01, 2'b11, 1, 7, 2, 8'h00, 32'h3FF0, 3'b000, 32'h3FF0, 4);
        tbl[13] = mk(2'b10, 2'b00, 2'b00, 5, 4, 0, 8'hFF, 32'h000C, 3'b000, 32'h000C, 4);
        tbl[14] = mk(2'b10, 2'b00, 2'b00, 7, 0, 0, 8'h01, 32'h8000, st_ov,  32'h8000, 4);

        t32[0] = mk(2'b00, 2'b00, 2'b00, 1, 0, 0, 8'h03, 32'h00000003, 3'b000, 32'h00000003, 2);
        t32[1] = mk(2'b00, 2'b00, 2'b00, 2, 0, 0, 8'h05, 32'h00000005, 3'b000, 32'h00000005, 2);
        t32[2] = mk(2'b01, 2'b00, 2'b01, 4, 1, 2, 8'h00, 32'h0000000D, 3'b000, 32'h0000000D, 4);
        t32[3] = mk(2'b00, 2'b00, 2'b00, 3, 0, 0, 8'h80, 32'hFFFFFF80, 3'b000, 32'hFFFFFF80, 2);

        reset_n = 1'b0; sel = 1'b0; cmd_valid = 1'b0; dbg_rnum = '0;
        c_mode = '0; c_op = '0; c_sh = '0; c_rd = '0; c_rn = '0; c_rm = '0; c_imm = '0;

        repeat (2) @(negedge clk);
        check("rst.ready", {31'h0, ready_m}, 32'h1);
        check("rst.done", {31'h0, done_m}, 32'h0);
        check("rst.dp_out", dp_m, 32'h0);
        check("rst.status", {29'h0, st_m}, 32'h0);
        reset_n = 1'b1;
        @(negedge clk);
        check("rst.ready_after", {31'h0, ready_m}, 32'h1);

        // Busy handling: valid stays high across two commands.
        va = mk(2'b00, 2'b00, 2'b00, 1, 0, 0, 8'h11, 0, 0, 0, 0);
        vb = mk(2'b00, 2'b00, 2'b00, 2, 0, 0, 8'h22, 0, 0, 0, 0);
        drive(va);
        cmd_valid = 1'b1;
        first = -1; second = -1; done_at = -1; nacc = 0;
        for (int e = 0; e < 12; e++) begin
            if (done_m === 1'b1 && done_at < 0) done_at = e;
            if (ready_m === 1'b1 && cmd_valid === 1'b1) begin
                nacc++;
                if (first < 0) first = e;
                else if (second < 0) second = e;
            end
            @(posedge clk);
            #1;
            if (e == first) drive(vb);
            if (e == second) cmd_valid = 1'b0;
            @(negedge clk);
        end
        check("busy.accepts", 32'(nacc), 32'd2);
        check("busy.spacing", 32'(second - first), 32'd3);
        check("busy.after_done", 32'(second - done_at), 32'd1);
        read_reg(1, rv);
        check("busy.r1", rv, 32'h0011);
        read_reg(2, rv);
        check("busy.r2", rv, 32'h0022);

        for (int i = 0; i < 15; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

        @(negedge clk);
        sel = 1'b1;
        for (int i = 0; i < 4; i++) run_vec(t32[i], $sformatf("w32_%0d", i));
        // Shift R3 = 0xFFFFFF80 left 24 times to reach 0x80000000.
        for (int i = 0; i < 24; i++) issue(mk(2'b01, 2'b00, 2'b01, 3, 0, 3, 8'h00, 0, 0, 0, 0), lat);
        read_reg(3, rv);
        check("w32.r3_msb", rv, 32'h80000000);
        check("w32.status_msb", {29'h0, st_m}, 32'h4);
        run_vec(mk(2'b01, 2'b00, 2'b11, 15, 0, 3, 8'h00, 32'hC0000000, 3'b100, 32'hC0000000, 4),
                "w32_asr");

        // Reset during EXEC of a MOVI aborts the writeback.
        @(negedge clk);
        sel = 1'b0;
        drive(mk(2'b00, 2'b00, 2'b00, 3, 0, 0, 8'h7F, 0, 0, 0, 0));
        cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        reset_n = 1'b0;
        #1;
        check("abort.done", {31'h0, done_m}, 32'h0);
        check("abort.ready", {31'h0, ready_m}, 32'h1);
        check("abort.status", {29'h0, st_m}, 32'h0);
        check("abort.dp_out", dp_m, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        done_seen = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (done_m === 1'b1) done_seen++;
        end
        check("abort.no_done", 32'(done_seen), 32'd0);
        check("abort.ready_after", {31'h0, ready_m}, 32'h1);
        read_reg(3, rv);
        check("abort.r3", rv, 32'h0);
        read_reg(7, rv);
        check("abort.r7", rv, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
